// File: rtl/spi_slave_stream.sv
// SPI slave streaming words from a TX FIFO out on MISO, any CPOL/CPHA, MSB first.
// Optional MOSI receive path is compiled in when SPI_SLAVE_RX_EN is defined.
module spi_slave_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [2:0] sck_sync_reg;
  logic [2:0] ss_sync_reg;
  logic       sck_lead, sck_trail, ss_fall, ss_rise;
  logic       sample_edge, drive_edge;

  // Sync flops reset to the idle pin levels so release from reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_reg <= {3{CPOL}};
      ss_sync_reg  <= 3'b111;
    end else begin
      sck_sync_reg <= {sck_sync_reg[1:0], SCK};
      ss_sync_reg  <= {ss_sync_reg[1:0], SS};
    end
  end

  assign sck_lead    = (sck_sync_reg[2] == CPOL) && (sck_sync_reg[1] != CPOL);
  assign sck_trail   = (sck_sync_reg[2] != CPOL) && (sck_sync_reg[1] == CPOL);
  assign ss_fall     = ss_sync_reg[2] && !ss_sync_reg[1];
  assign ss_rise     = !ss_sync_reg[2] && ss_sync_reg[1];
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign drive_edge  = CPHA ? sck_lead : sck_trail;

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full, empty, push, pop, load;
  logic             frame_start, word_load;
  logic [WIDTH-1:0] load_word;

  state_t           state_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic             first_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic             miso_reg;
  logic             underrun_reg;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // With CPHA=1 the first drive edge of a frame precedes any sampling, so it must not reload.
  assign frame_start = (state_reg == IDLE) && ss_fall;
  assign word_load   = (state_reg == ACTIVE) && !ss_rise && drive_edge &&
                       (bit_cnt_reg == '0) && !(CPHA && first_reg);
  assign load        = frame_start || word_load;
  assign pop         = load && !empty;
  assign push        = tx_valid && !full;
  assign load_word   = empty ? {WIDTH{1'b1}} : fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      first_reg    <= 1'b0;
      tx_shift_reg <= {WIDTH{1'b1}};
      miso_reg     <= 1'b1;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= load && empty;
      case (state_reg)
        IDLE: begin
          if (ss_fall) begin
            state_reg    <= ACTIVE;
            bit_cnt_reg  <= '0;
            first_reg    <= 1'b1;
            tx_shift_reg <= load_word;
            miso_reg     <= load_word[WIDTH-1];
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b1;
          end else begin
            if (sample_edge)
              bit_cnt_reg <= (bit_cnt_reg == BW'(WIDTH-1)) ? '0 : bit_cnt_reg + 1'b1;
            if (drive_edge) begin
              first_reg <= 1'b0;
              if (word_load) begin
                tx_shift_reg <= load_word;
                miso_reg     <= load_word[WIDTH-1];
              end else if (bit_cnt_reg != '0) begin
                tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
                miso_reg     <= tx_shift_reg[WIDTH-2];
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MISO        = miso_reg;
  assign tx_ready    = !full;
  assign tx_underrun = underrun_reg;

`ifdef SPI_SLAVE_RX_EN
  logic [2:0]       mosi_sync_reg;
  logic [WIDTH-1:0] rx_shift_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg;
  logic             unused_mosi_tap;

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_reg <= 3'b000;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
    end else begin
      mosi_sync_reg <= {mosi_sync_reg[1:0], MOSI};
      rx_valid_reg  <= 1'b0;
      if ((state_reg == ACTIVE) && !ss_rise && sample_edge) begin
        rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], mosi_sync_reg[1]};
        if (bit_cnt_reg == BW'(WIDTH-1)) begin
          rx_data_reg  <= {rx_shift_reg[WIDTH-2:0], mosi_sync_reg[1]};
          rx_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign unused_mosi_tap = mosi_sync_reg[2];
  assign rx_data         = rx_data_reg;
  assign rx_valid        = rx_valid_reg;
`else
  logic unused_mosi_pin;
  assign unused_mosi_pin = MOSI;
  assign rx_data         = '0;
  assign rx_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// Drives four slaves (one per CPOL/CPHA mode) with shared stimulus and checks each
// against a frame-level model: word loads per frame, bit stream, underruns, RX words.
module tb_spi_slave_stream;

  localparam int W = 16;
  localparam int D = 8;
`ifdef SPI_SLAVE_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck_base = 1'b0;
  logic         SS = 1'b1;
  logic         MOSI = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;

  logic [3:0]   sck_m, miso_w, tx_ready_w, und_w, rxv_w;
  logic [W-1:0] rx_data_w [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam bit P_CPOL = bit'(gi / 2);
    localparam bit P_CPHA = bit'(gi % 2);
    assign sck_m[gi] = sck_base ^ P_CPOL;
    spi_slave_stream #(.WIDTH(W), .DEPTH(D), .CPOL(P_CPOL), .CPHA(P_CPHA)) u_dut (
      .clk(clk), .rst(rst), .SCK(sck_m[gi]), .SS(SS), .MOSI(MOSI), .MISO(miso_w[gi]),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_w[gi]),
      .tx_underrun(und_w[gi]), .rx_data(rx_data_w[gi]), .rx_valid(rxv_w[gi])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int und_cnt [4] = '{0, 0, 0, 0};
  int rxv_cnt [4] = '{0, 0, 0, 0};
  logic [W-1:0] rx_last [4];

  // Pulse counters: a pulse held two cycles counts twice and shows up as a count error.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (und_w[m]) und_cnt[m]++;
      if (rxv_w[m]) begin
        rxv_cnt[m]++;
        rx_last[m] = rx_data_w[m];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference FIFO per mode
  logic [W-1:0] mdat [4][D];
  int mhead [4] = '{0, 0, 0, 0};
  int mcnt  [4] = '{0, 0, 0, 0};

  task automatic model_push(input int m, input logic [W-1:0] d);
    if (mcnt[m] < D) begin
      mdat[m][(mhead[m] + mcnt[m]) % D] = d;
      mcnt[m]++;
    end
  endtask

  task automatic model_load(input int m, output logic [W-1:0] d, output bit was_empty);
    was_empty = (mcnt[m] == 0);
    if (was_empty) d = '1;
    else begin
      d = mdat[m][mhead[m]];
      mhead[m] = (mhead[m] + 1) % D;
      mcnt[m]--;
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int m = 0; m < 4; m++)
      check_eq($sformatf("m%0d tx_ready before push", m), 64'(tx_ready_w[m]), 64'(mcnt[m] < D));
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int m = 0; m < 4; m++) model_push(m, d);
  endtask

  // One SS frame of n full SCK cycles (1..60); the master samples MISO just before each sample edge.
  task automatic run_frame(input int n);
    int           und0 [4], rxv0 [4];
    logic [63:0]  cap [4];
    logic [63:0]  mosi_word, exp_bits;
    logic [W-1:0] words [8];
    logic [W-1:0] d;
    bit           e;
    int           loads, exp_und, ncomp;
    mosi_word = {$urandom, $urandom};
    for (int m = 0; m < 4; m++) begin
      und0[m] = und_cnt[m];
      rxv0[m] = rxv_cnt[m];
      cap[m]  = '0;
    end
    MOSI = mosi_word[63];
    SS = 1'b0;
    wait_clk(5);
    for (int i = 0; i < n; i++) begin
      for (int m = 0; m < 4; m += 2) cap[m][63-i] = miso_w[m];
      sck_base = 1'b1;
      wait_clk(5);
      for (int m = 1; m < 4; m += 2) cap[m][63-i] = miso_w[m];
      sck_base = 1'b0;
      wait_clk(2);
      if (i < 63) MOSI = mosi_word[62-i];
      wait_clk(3);
    end
    wait_clk(2);
    SS = 1'b1;
    wait_clk(6);
    for (int m = 0; m < 4; m++) begin
      // CPHA=0 reloads on every trailing edge that closes a word; CPHA=1 on leading edges after the first.
      loads = (m % 2 == 0) ? 1 + n / W : 1 + (n - 1) / W;
      exp_und = 0;
      for (int l = 0; l < loads; l++) begin
        model_load(m, d, e);
        words[l] = d;
        if (e) exp_und++;
      end
      exp_bits = '0;
      for (int i = 0; i < n; i++) exp_bits[63-i] = words[i / W][W-1 - (i % W)];
      ncomp = n / W;
      check_eq($sformatf("m%0d n%0d miso bits", m, n), cap[m], exp_bits);
      check_eq($sformatf("m%0d n%0d underrun pulses", m, n), 64'(und_cnt[m] - und0[m]), 64'(exp_und));
      check_eq($sformatf("m%0d n%0d rx_valid pulses", m, n), 64'(rxv_cnt[m] - rxv0[m]),
               RX_EN ? 64'(ncomp) : 64'(0));
      if (RX_EN && ncomp > 0)
        check_eq($sformatf("m%0d n%0d rx_data", m, n), 64'(rx_last[m]),
                 64'(mosi_word[63 - W*(ncomp-1) -: W]));
      else if (!RX_EN)
        check_eq($sformatf("m%0d rx_data tied", m), 64'(rx_data_w[m]), 64'(0));
      check_eq($sformatf("m%0d tx_ready after frame", m), 64'(tx_ready_w[m]), 64'(mcnt[m] < D));
      check_eq($sformatf("m%0d idle miso", m), 64'(miso_w[m]), 64'(1));
    end
    $display("frame n=%0d sck cycles, fifo levels %0d %0d %0d %0d", n, mcnt[0], mcnt[1], mcnt[2], mcnt[3]);
  endtask

  initial begin
    logic [W-1:0] d;
    bit           e;
    int           np;

    wait_clk(4);
    rst = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check_eq($sformatf("m%0d reset miso", m), 64'(miso_w[m]), 64'(1));
      check_eq($sformatf("m%0d reset tx_ready", m), 64'(tx_ready_w[m]), 64'(1));
      check_eq($sformatf("m%0d reset underrun", m), 64'(und_w[m]), 64'(0));
      check_eq($sformatf("m%0d reset rx_valid", m), 64'(rxv_w[m]), 64'(0));
      check_eq($sformatf("m%0d reset rx_data", m), 64'(rx_data_w[m]), 64'(0));
    end

    push_word(16'hA5C3);
    run_frame(16);
    push_word(16'h8001);
    push_word(16'h7FFE);
    run_frame(32);
    run_frame(32);

    for (int k = 0; k < 9; k++) push_word(16'h1100 + 16'(k));
    run_frame(16);
    run_frame(5);
    run_frame(16);

    // Reset in the middle of a frame with the FIFO full
    for (int k = 0; k < 8; k++) push_word(16'h3300 + 16'(k));
    SS = 1'b0;
    wait_clk(5);
    for (int m = 0; m < 4; m++) model_load(m, d, e);
    push_word(16'h4444);
    for (int m = 0; m < 4; m++)
      check_eq($sformatf("m%0d tx_ready full mid-frame", m), 64'(tx_ready_w[m]), 64'(mcnt[m] < D));
    for (int i = 0; i < 5; i++) begin
      sck_base = 1'b1;
      wait_clk(5);
      sck_base = 1'b0;
      wait_clk(5);
    end
    rst = 1'b1;
    SS = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check_eq($sformatf("m%0d miso after rst", m), 64'(miso_w[m]), 64'(1));
      check_eq($sformatf("m%0d tx_ready after rst", m), 64'(tx_ready_w[m]), 64'(1));
      mcnt[m] = 0;
      mhead[m] = 0;
    end
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    run_frame(32);

    for (int r = 0; r < 6; r++) begin
      np = $urandom_range(0, 9);
      for (int k = 0; k < np; k++) push_word(16'($urandom));
      run_frame($urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
